// File: rtl/axil_bram_wide_arbiter.sv
// AXI4-Lite slave serving one port of a wide BRAM: read/write arbitration, lane select, byte enables, configurable read latency.
// Optional misaligned-access SLVERR response enabled by defining AXIL_BRAM_ALIGN_CHECK_EN.
module axil_bram_wide_arbiter #(
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned BRAM_DATA_WIDTH = 64,
  parameter int unsigned DEINTERLEAVE    = BRAM_DATA_WIDTH / AXI_DATA_WIDTH,
  parameter int unsigned BRAM_ADDR_WIDTH = 10,
  parameter int unsigned AXI_ADDR_WIDTH  = BRAM_ADDR_WIDTH + $clog2(DEINTERLEAVE),
  parameter int unsigned READ_LATENCY    = 1
) (
  input  logic                         axi_clock,
  input  logic                         rst,
  input  logic [AXI_ADDR_WIDTH+1:0]    s_axil_awaddr,
  input  logic [2:0]                   s_axil_awprot,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]  s_axil_wstrb,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  output logic [1:0]                   s_axil_bresp,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  input  logic [AXI_ADDR_WIDTH+1:0]    s_axil_araddr,
  input  logic [2:0]                   s_axil_arprot,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_din,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_we,
  output logic                         bram_en,
  input  logic [BRAM_DATA_WIDTH-1:0]   bram_dout
);

  localparam int unsigned AXI_STRB_W  = AXI_DATA_WIDTH / 8;
  localparam int unsigned BRAM_STRB_W = BRAM_DATA_WIDTH / 8;
  localparam int unsigned LANE_W      = (DEINTERLEAVE > 1) ? $clog2(DEINTERLEAVE) : 1;
  localparam int unsigned CNT_W       = 2;

  typedef enum logic [2:0] {IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP} state_t;

  state_t                      state, state_next;
  logic                        prio_wr;
  logic [CNT_W-1:0]            lat_cnt;
  logic [LANE_W-1:0]           rd_lane;
  logic                        grant_wr, grant_rd;
  logic                        aw_misaligned, ar_misaligned;
  logic [AXI_ADDR_WIDTH-1:0]   aw_word, ar_word;
  logic [BRAM_ADDR_WIDTH-1:0]  aw_row, ar_row;
  logic [LANE_W-1:0]           aw_lane, ar_lane;
  logic [BRAM_STRB_W-1:0]      wr_we;
  logic [AXI_DATA_WIDTH-1:0]   rd_slice;
  logic                        unused;

  assign aw_word = s_axil_awaddr[AXI_ADDR_WIDTH+1:2];
  assign ar_word = s_axil_araddr[AXI_ADDR_WIDTH+1:2];
  assign aw_row  = aw_word[AXI_ADDR_WIDTH-1 -: BRAM_ADDR_WIDTH];
  assign ar_row  = ar_word[AXI_ADDR_WIDTH-1 -: BRAM_ADDR_WIDTH];

  if (DEINTERLEAVE > 1) begin : g_lane
    assign aw_lane = aw_word[LANE_W-1:0];
    assign ar_lane = ar_word[LANE_W-1:0];
  end else begin : g_no_lane
    assign aw_lane = '0;
    assign ar_lane = '0;
  end

`ifdef AXIL_BRAM_ALIGN_CHECK_EN
  assign aw_misaligned = (s_axil_awaddr[1:0] != 2'b00);
  assign ar_misaligned = (s_axil_araddr[1:0] != 2'b00);
`else
  assign aw_misaligned = 1'b0;
  assign ar_misaligned = 1'b0;
`endif

  assign unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // Handshakes are single-cycle grants issued from IDLE only.
  assign s_axil_awready = grant_wr;
  assign s_axil_wready  = grant_wr;
  assign s_axil_arready = grant_rd;

  // Strobes land only in the addressed lane of the row.
  always_comb begin
    wr_we = '0;
    for (int unsigned i = 0; i < DEINTERLEAVE; i++)
      if (aw_lane == LANE_W'(i)) wr_we[i*AXI_STRB_W +: AXI_STRB_W] = s_axil_wstrb;
  end

  always_comb begin
    rd_slice = '0;
    for (int unsigned i = 0; i < DEINTERLEAVE; i++)
      if (rd_lane == LANE_W'(i)) rd_slice = bram_dout[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

  // Next state and grants; priority flag breaks read/write collisions.
  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state)
      IDLE: begin
        grant_wr = rst && s_axil_awvalid && s_axil_wvalid && (!s_axil_arvalid || prio_wr);
        grant_rd = rst && s_axil_arvalid && !grant_wr;
        if (grant_wr)      state_next = aw_misaligned ? WR_RESP : WR_EXEC;
        else if (grant_rd) state_next = ar_misaligned ? RD_RESP : RD_EXEC;
      end
      WR_EXEC: state_next = WR_RESP;
      WR_RESP: if (s_axil_bready) state_next = IDLE;
      RD_EXEC: state_next = RD_WAIT;
      RD_WAIT: if (lat_cnt == '0) state_next = RD_RESP;
      RD_RESP: if (s_axil_rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_clock or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prio_wr <= 1'b0;
      lat_cnt <= '0;
    end else begin
      state <= state_next;
      if (grant_wr)      prio_wr <= 1'b0;
      else if (grant_rd) prio_wr <= 1'b1;
      if (state == RD_EXEC)                     lat_cnt <= CNT_W'(READ_LATENCY - 1);
      else if (state == RD_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - CNT_W'(1);
    end
  end

  // Registered BRAM port and AXI response channels.
  always_ff @(posedge axi_clock or negedge rst) begin
    if (!rst) begin
      bram_en       <= 1'b0;
      bram_we       <= '0;
      bram_addr     <= '0;
      bram_din      <= '0;
      rd_lane       <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= 2'b00;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= 2'b00;
      s_axil_rdata  <= '0;
    end else begin
      bram_en <= 1'b0;
      bram_we <= '0;
      if (grant_wr) begin
        s_axil_bresp <= aw_misaligned ? 2'b10 : 2'b00;
        if (!aw_misaligned) begin
          bram_en   <= 1'b1;
          bram_we   <= wr_we;
          bram_addr <= aw_row;
          bram_din  <= BRAM_DATA_WIDTH'({DEINTERLEAVE{s_axil_wdata}});
        end
      end
      if (grant_rd) begin
        s_axil_rresp <= ar_misaligned ? 2'b10 : 2'b00;
        if (ar_misaligned) begin
          s_axil_rdata <= '0;
        end else begin
          bram_en   <= 1'b1;
          bram_addr <= ar_row;
          rd_lane   <= ar_lane;
        end
      end
      if (state == RD_WAIT && lat_cnt == '0) s_axil_rdata <= rd_slice;
      s_axil_bvalid <= (state_next == WR_RESP);
      s_axil_rvalid <= (state_next == RD_RESP);
    end
  end

endmodule

// File: tb/tb_axil_bram_wide_arbiter.sv
// Self-checking bench for axil_bram_wide_arbiter (32-bit AXI, 64-bit rows, read latency 2).
// Expectations come from a word-addressed reference memory and byte-address arithmetic.
module tb_axil_bram_wide_arbiter;

  localparam int RL = 2;
`ifdef AXIL_BRAM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [9:0]  bram_addr;
  logic [63:0] bram_din, bram_dout;
  logic [7:0]  bram_we;
  logic        bram_en;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [31:0] ref_mem [0:2047];
  logic [63:0] mem [0:1023];
  logic [63:0] pipe [RL];

  axil_bram_wide_arbiter #(.READ_LATENCY(RL)) dut (
    .axi_clock(clk), .rst(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_en(bram_en),
    .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM with RL-cycle read pipeline, read-before-write.
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 8; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
      pipe[0] <= mem[bram_addr];
    end
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign bram_dout = pipe[RL-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [12:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int bdelay, output int t_acc, output int t_done);
    int n;
    int lane;
    logic mis;
    logic [7:0] exp_we;
    logic [1:0] exp_resp;
    mis = ALIGN_EN && (addr[1:0] != 2'b00);
    lane = (int'(addr) / 4) % 2;
    exp_we = 8'(int'(strb) << (4 * lane));
    exp_resp = mis ? 2'b10 : 2'b00;
    t_acc = -1; t_done = -1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready === 1'b1 && wready === 1'b1) && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!(awready === 1'b1 && wready === 1'b1)) begin
      fails++;
      $display("FAIL aw_w_accept addr=%h: awready=%b wready=%b, required 1/1", addr, awready, wready);
      @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    t_acc = cyc;
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    if (!mis) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[int'(addr) / 4][8*b +: 8] = data[8*b +: 8];
      @(negedge clk);
      checks++;
      if (bram_en !== 1'b1 || bram_addr !== 10'(int'(addr) / 8) || bram_we !== exp_we || bram_din !== {data, data}) begin
        fails++;
        $display("FAIL wr_exec addr=%h: en=%b row=%h we=%h din=%h, required en=1 row=%h we=%h din=%h",
                 addr, bram_en, bram_addr, bram_we, bram_din, 10'(int'(addr) / 8), exp_we, {data, data});
      end
    end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || bresp !== exp_resp || bram_en !== 1'b0) begin
      fails++;
      $display("FAIL wr_resp addr=%h: bvalid=%b bresp=%b en=%b, required 1/%b/0", addr, bvalid, bresp, bram_en, exp_resp);
    end
    for (int k = 0; k < bdelay; k++) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || arready !== 1'b0 || awready !== 1'b0) begin
        fails++;
        $display("FAIL b_hold addr=%h: bvalid=%b arready=%b awready=%b, required 1/0/0", addr, bvalid, arready, awready);
      end
    end
    @(posedge clk); #1 bready = 1'b1;
    @(negedge clk); t_done = cyc;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic do_read(input logic [12:0] addr, input int rdelay, output int t_acc, output int t_done);
    int n;
    logic mis;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    mis = ALIGN_EN && (addr[1:0] != 2'b00);
    t_acc = -1; t_done = -1;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (arready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (arready !== 1'b1) begin
      fails++;
      $display("FAIL ar_accept addr=%h: arready=%b, required 1", addr, arready);
      @(posedge clk); #1 arvalid = 1'b0;
      return;
    end
    t_acc = cyc;
    exp_data = mis ? 32'h0 : ref_mem[int'(addr) / 4];
    exp_resp = mis ? 2'b10 : 2'b00;
    @(posedge clk); #1 arvalid = 1'b0;
    if (!mis) begin
      @(negedge clk);
      checks++;
      if (bram_en !== 1'b1 || bram_we !== 8'h00 || bram_addr !== 10'(int'(addr) / 8)) begin
        fails++;
        $display("FAIL rd_exec addr=%h: en=%b we=%h row=%h, required 1/00/%h", addr, bram_en, bram_we, bram_addr, 10'(int'(addr) / 8));
      end
      for (int k = 0; k < RL; k++) begin
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || bram_en !== 1'b0) begin
          fails++;
          $display("FAIL rd_wait addr=%h step=%0d: rvalid=%b en=%b, required 0/0", addr, k, rvalid, bram_en);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rresp !== exp_resp || rdata !== exp_data || bram_en !== 1'b0) begin
      fails++;
      $display("FAIL rd_resp addr=%h: rvalid=%b rresp=%b rdata=%h en=%b, required 1/%b/%h/0",
               addr, rvalid, rresp, rdata, bram_en, exp_resp, exp_data);
    end
    for (int k = 0; k < rdelay; k++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_data || arready !== 1'b0) begin
        fails++;
        $display("FAIL r_hold addr=%h: rvalid=%b rdata=%h arready=%b, required 1/%h/0", addr, rvalid, rdata, arready, exp_data);
      end
    end
    @(posedge clk); #1 rready = 1'b1;
    @(negedge clk); t_done = cyc;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awaddr = 13'h004; araddr = 13'h008; wdata = 32'h1; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bram_en} !== 6'b0 || bram_we !== 8'h0 ||
        bram_addr !== 10'h0 || bram_din !== 64'h0 || rdata !== 32'h0 || bresp !== 2'b0 || rresp !== 2'b0) begin
      fails++;
      $display("FAIL reset_outputs: aw/w/ar/b/r/en=%b we=%h addr=%h din=%h rdata=%h, required all zero",
               {awready, wready, arready, bvalid, rvalid, bram_en}, bram_we, bram_addr, bram_din, rdata);
    end
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, arready, bvalid, rvalid, bram_en} !== 5'b0) begin
      fails++;
      $display("FAIL idle_after_reset: aw/ar/b/r/en=%b, required 00000", {awready, arready, bvalid, rvalid, bram_en});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int unused_a, unused_b;
    do_write(13'h004, 32'hDEADBEEF, 4'hF, 0, unused_a, unused_b);
    do_write(13'h000, 32'h12345678, 4'hF, 1, unused_a, unused_b);
    do_write(13'h008, 32'h000000AB, 4'b0001, 0, unused_a, unused_b);
  endtask

  task automatic test_read();
    int ta, unused_b;
    do_read(13'h004, 0, ta, unused_b);
    do_read(13'h000, 2, ta, unused_b);
  endtask

  task automatic test_collision();
    int ra, rd_done, wa, unused_w;
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      fork
        do_read(rep == 0 ? 13'h000 : 13'h010, 0, ra, rd_done);
        do_write(rep == 0 ? 13'h010 : 13'h014, 32'hCAFE0000 + 32'(rep), 4'hF, 0, wa, unused_w);
      join
      checks++;
      if (ra < 0 || wa != rd_done + 1) begin
        fails++;
        $display("FAIL collision_order rep=%0d: read accepted %0d done %0d, write accepted %0d, required write at %0d",
                 rep, ra, rd_done, wa, rd_done + 1);
      end
    end
  endtask

  task automatic test_bready_stall();
    int unused_a, wd, ra, unused_b;
    fork
      do_write(13'h020, 32'h0BADF00D, 4'hF, 5, unused_a, wd);
      begin
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        do_read(13'h020, 0, ra, unused_b);
      end
    join
    checks++;
    if (ra != wd + 1) begin
      fails++;
      $display("FAIL stall_ar_accept: read accepted %0d, required %0d", ra, wd + 1);
    end
  endtask

  task automatic test_random();
    int unused_a, unused_b;
    int w;
    for (int i = 0; i < 16; i++)
      do_write(13'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), unused_a, unused_b);
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1)
        do_write(13'(w * 4), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), unused_a, unused_b);
      else
        do_read(13'(w * 4), $urandom_range(0, 3), unused_a, unused_b);
    end
  endtask

  task automatic test_reset_mid_read();
    int n, unused_a, unused_b;
    araddr = 13'h03C; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (arready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    araddr = 13'h000; arvalid = 1'b1; rst_n = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || bram_en !== 1'b0 || arready !== 1'b0 || bram_addr !== 10'h0 || rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_read: rvalid=%b en=%b arready=%b row=%h rdata=%h, required all zero",
               rvalid, bram_en, arready, bram_addr, rdata);
    end
    @(posedge clk); #1 arvalid = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0 || bvalid !== 1'b0 || bram_en !== 1'b0) begin
        fails++;
        $display("FAIL dropped_txn cycle=%0d: rvalid=%b bvalid=%b en=%b, required 0/0/0", k, rvalid, bvalid, bram_en);
      end
    end
    @(posedge clk); #1;
    do_read(13'h03C, 1, unused_a, unused_b);
  endtask

  task automatic test_align();
    int unused_a, unused_b;
    do_read(13'h006, 0, unused_a, unused_b);
    do_write(13'h00A, 32'h5555AAAA, 4'hF, 0, unused_a, unused_b);
    do_read(13'h008, 0, unused_a, unused_b);
  endtask

  initial begin
    awprot = 3'b0; arprot = 3'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    test_reset();
    test_write();
    test_read();
    test_collision();
    test_bready_stall();
    test_random();
    test_reset_mid_read();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axil_bram_wide_arbiter.md
Name: axil_bram_wide_arbiter

Overview:
Single-clock AXI4-Lite slave that turns AXI-lite reads and writes into one port of a wide BRAM. Each BRAM row is DEINTERLEAVE AXI words wide. The block handles arbitration between read and write requests, lane selection, byte-enable generation and a configurable BRAM read latency. It is the generalised successor to the fixed-latency, single-width arbiter. It sits between the interconnect and port B of an unbalanced/wide RAM.

Parameters:
AXI_DATA_WIDTH, 32, AXI word width (multiple of 8).
BRAM_DATA_WIDTH, 64, BRAM row width; integer multiple of AXI_DATA_WIDTH.
DEINTERLEAVE, BRAM_DATA_WIDTH/AXI_DATA_WIDTH, AXI words per row (power of 2, >=1).
BRAM_ADDR_WIDTH, 10, row address width.
AXI_ADDR_WIDTH, BRAM_ADDR_WIDTH+$clog2(DEINTERLEAVE), AXI word address width.
READ_LATENCY, 1, BRAM cycles from en to valid dout (1..4).

Ports:
axi_clock  in  1  sole clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
s_axil_awaddr  in  AXI_ADDR_WIDTH+2  byte write address
s_axil_awprot  in  3  ignored
s_axil_awvalid / s_axil_awready  in/out  1  AW handshake
s_axil_wdata  in  AXI_DATA_WIDTH  write data
s_axil_wstrb  in  AXI_DATA_WIDTH/8  byte strobes
s_axil_wvalid / s_axil_wready  in/out  1  W handshake
s_axil_bresp  out  2  write response
s_axil_bvalid / s_axil_bready  out/in  1  B handshake
s_axil_araddr  in  AXI_ADDR_WIDTH+2  byte read address
s_axil_arprot  in  3  ignored
s_axil_arvalid / s_axil_arready  in/out  1  AR handshake
s_axil_rdata  out  AXI_DATA_WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid / s_axil_rready  out/in  1  R handshake
bram_addr  out  BRAM_ADDR_WIDTH  row address
bram_din  out  BRAM_DATA_WIDTH  write data, wdata replicated across all lanes
bram_we  out  BRAM_DATA_WIDTH/8  byte write enables
bram_en  out  1  port enable
bram_dout  in  BRAM_DATA_WIDTH  row read data

Behaviour:
- Address decode: word = addr[AXI_ADDR_WIDTH+1:2]. lane = word[$clog2(DEINTERLEAVE)-1:0]. row = word upper BRAM_ADDR_WIDTH bits. When DEINTERLEAVE=1, lane is 0.
- One transaction in flight at a time. FSM states: IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP.
- IDLE, write request: a write is pending only when awvalid and wvalid are both 1. awready and wready pulse together for 1 cycle (cycle T). They are never asserted separately.
- IDLE, read request: arvalid=1 is a read request. arready pulses for 1 cycle (cycle T).
- Simultaneous read and write requests: a priority flag alternates. After reset, read wins. After any granted write, read has priority next; after any granted read, write has priority next.
- WR_EXEC (T+1): bram_en=1, bram_addr=row, bram_din=wdata replicated. bram_we = wstrb placed at lane position; all other lanes get 0.
- WR_RESP: bvalid=1 from T+2, bresp=00. bvalid holds until bready; the FSM returns to IDLE on the cycle after the handshake.
- RD_EXEC (T+1): bram_en=1, bram_we=0, bram_addr=row.
- RD_WAIT: counts READ_LATENCY-1 further cycles. At the end of cycle T+1+READ_LATENCY, rdata is loaded with the latched lane slice of bram_dout.
- RD_RESP: rvalid=1 from T+2+READ_LATENCY, rresp=00. rvalid holds until rready. rdata stays stable while rvalid=1.
- Outside EXEC states: bram_en=0 and bram_we=0. bram_addr and bram_din hold their last values.
- Ready signals: all ready outputs are 0 outside IDLE and during reset. Earliest next accept is the cycle after a B or R handshake.
- Reset (any time, including mid-transaction): every output goes to 0 immediately. State returns to IDLE, the priority flag selects read, and the transaction in flight is dropped with no response.

Optional Feature:
AXIL_BRAM_ALIGN_CHECK_EN.
- Defined: a request with addr[1:0]!=0 is still accepted. It skips the EXEC/WAIT states, so bram_en stays 0. The response is issued at T+1 with resp=10 (SLVERR); on a read, rdata=0.
- Undefined: addr[1:0] is ignored and the access proceeds normally with resp=00.

Test Plan:
1. DEINTERLEAVE=2: write 0xDEADBEEF to byte 0x04, wstrb=0xF -> at T+1 bram_addr=0, bram_we=0xF0, bram_din=0xDEADBEEFDEADBEEF; bvalid at T+2 with bresp=00.
2. READ_LATENCY=2, BRAM model holding row 0 = 0xDEADBEEF12345678; read byte 0x04 -> bram_en at T+1, rvalid at T+4, rdata=0xDEADBEEF. Read 0x00 -> rdata=0x12345678.
3. After reset, AW/W and AR asserted in the same cycle -> arready first and read completes; then awready+wready. Repeat the collision -> read wins again.
4. Write 0x000000AB to byte 0x08 with wstrb=0b0001 -> bram_addr=1, bram_we=0x01.
5. bready held 0 for 5 cycles -> bvalid held, no ready asserted, and a concurrent arvalid stays unaccepted until after the handshake.
6. rst driven low in RD_WAIT -> rvalid, bram_en and arready are 0 immediately. After release, a fresh read completes normally. With AXIL_BRAM_ALIGN_CHECK_EN defined, a read of 0x06 -> rresp=10 at T+1, bram_en never asserted.
